// File: rtl/keypad_pkg.sv
// Shared state encoding and width helpers for the keypad scanner.
package keypad_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    SCAN     = ST_SCAN,
    DEBOUNCE = ST_DEBOUNCE,
    HOLD     = ST_HOLD,
    RELEASE  = ST_RELEASE
  } state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_w(input int rows, input int cols);
    return idx_w(rows * cols);
  endfunction

  function automatic int col_idx_w(input int cols);
    return idx_w(cols);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2 clk latency, no backpressure.
// Resets to all ones so released (pulled-up) inputs read idle.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner emitting one debounced key code per press; key_valid 1 clk after the last debounce tick.
// key_valid is held until key_ready; scan_ena drops while a key waits, stalling the scan divider.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   scan_tick,
  input  logic [NUM_ROWS-1:0]                    row_n,
  output logic [NUM_COLS-1:0]                    col_n,
  output logic                                   scan_ena,
  output logic                                   key_valid,
  input  logic                                   key_ready,
  output logic [key_w(NUM_ROWS, NUM_COLS)-1:0]   key_code,
  output logic                                   key_held
);

  localparam int KEY_W = key_w(NUM_ROWS, NUM_COLS);
  localparam int COL_W = col_idx_w(NUM_COLS);
  localparam int ROW_W = idx_w(NUM_ROWS);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [NUM_ROWS-1:0] row_s;

  sync_2ff #(
    .WIDTH (NUM_ROWS)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  state_t           state, state_nxt;
  logic [COL_W-1:0] col_idx, col_idx_nxt;
  logic [ROW_W-1:0] row_idx, row_idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_valid_nxt;
  logic [KEY_W-1:0] key_code_nxt;
  logic             key_held_nxt;

  logic             tick;
  logic             any_low;
  logic [ROW_W-1:0] low_row;
  logic             latched_low;
  logic [COL_W-1:0] col_adv;
  logic [KEY_W-1:0] code_now;

  assign scan_ena    = (state != HOLD);
  assign tick        = scan_tick & scan_ena;
  assign col_n       = ~(NUM_COLS'(1) << col_idx);
  assign latched_low = ~row_s[row_idx];
  assign col_adv     = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
  assign code_now    = KEY_W'(KEY_W'(row_idx) * KEY_W'(NUM_COLS)) + KEY_W'(col_idx);

  // Lowest-index low row wins when several rows drop on the same column.
  always_comb begin
    any_low = 1'b0;
    low_row = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) begin
        any_low = 1'b1;
        low_row = ROW_W'(r);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      row_idx   <= row_idx_nxt;
      cnt       <= cnt_nxt;
      key_valid <= key_valid_nxt;
      key_code  <= key_code_nxt;
      key_held  <= key_held_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    row_idx_nxt   = row_idx;
    cnt_nxt       = cnt;
    key_valid_nxt = key_valid;
    key_code_nxt  = key_code;
    key_held_nxt  = key_held;

    unique case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            row_idx_nxt = low_row;
            cnt_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            col_idx_nxt = col_adv;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (latched_low) begin
            if (cnt == CNT_LAST) begin
              key_code_nxt  = code_now;
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              state_nxt     = HOLD;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            col_idx_nxt = col_adv;
            state_nxt   = SCAN;
          end
        end
      end

      // Column stays frozen and ticks are masked until the consumer takes the key.
      HOLD: begin
        if (key_valid && key_ready) begin
          key_valid_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = RELEASE;
        end
      end

      RELEASE: begin
        if (tick) begin
          if (latched_low) begin
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              key_held_nxt = 1'b0;
              col_idx_nxt  = col_adv;
              state_nxt    = SCAN;
            end
          end
        end
      end

      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad matrix model drives row_n from col_n,
// expected key codes are queued at stimulus time and popped by an accept monitor.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       scan_tick;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       scan_ena;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_held;

  logic [3:0][3:0] pressed;

  int checks   = 0;
  int failures = 0;
  int n_pushed = 0;
  int n_acc    = 0;
  int exp_q[$];

  keypad_scan_ctrl #(
    .NUM_ROWS       (4),
    .NUM_COLS       (4),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_tick (scan_tick),
    .row_n     (row_n),
    .col_n     (col_n),
    .scan_ena  (scan_ena),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low when a pressed key sits on a column currently driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int code);
    exp_q.push_back(code);
    n_pushed++;
  endtask

  // Accept monitor: samples on the falling edge, before the edge that accepts.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key: got code %0h expected no key at %0t", key_code, $time);
      end else begin
        chk("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    step();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r][c] = v;
    repeat (3) step();
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    scan_tick = 1'b0;
    key_ready = 1'b1;
    pressed   = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_col_n", 32'(col_n), 32'hE);
    chk("rst_scan_ena", 32'(scan_ena), 32'h1);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);

    // 1: idle rotation over 8 ticks
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_col;
      tick();
      exp_col = ~(4'b0001 << ((i + 1) % 4));
      chk("idle_col_n", 32'(col_n), 32'(exp_col));
      chk("idle_key_valid", 32'(key_valid), 32'h0);
    end

    // 2: row 2 on col 1 -> code 9, ready tied high
    push_exp(9);
    set_key(2, 1, 1'b1);
    tick();
    chk("t2_col1", 32'(col_n), 32'hD);
    tick();
    ticks(3);
    chk("t2_early_valid", 32'(key_valid), 32'h0);
    chk("t2_early_held", 32'(key_held), 32'h0);
    tick();
    chk("t2_held", 32'(key_held), 32'h1);
    chk("t2_valid_pulse", 32'(key_valid), 32'h0);
    chk("t2_scan_ena", 32'(scan_ena), 32'h1);
    chk("t2_col_frozen", 32'(col_n), 32'hD);
    set_key(2, 1, 1'b0);
    ticks(3);
    chk("t2_rel_held3", 32'(key_held), 32'h1);
    tick();
    chk("t2_rel_held4", 32'(key_held), 32'h0);
    chk("t2_rel_col", 32'(col_n), 32'hB);
    chk("t2_code_kept", 32'(key_code), 32'h9);

    // 3: bounce on col 2, never emitted
    set_key(0, 2, 1'b1);
    ticks(3);
    set_key(0, 2, 1'b0);
    tick();
    chk("t3_col_adv", 32'(col_n), 32'h7);
    chk("t3_held", 32'(key_held), 32'h0);
    chk("t3_scan_ena", 32'(scan_ena), 32'h1);

    // 4: consumer stalls 50 clk
    key_ready = 1'b0;
    push_exp(15);
    set_key(3, 3, 1'b1);
    ticks(5);
    for (int i = 0; i < 50; i++) begin
      scan_tick = (i % 5 == 0);
      step();
      chk("t4_valid", 32'(key_valid), 32'h1);
      chk("t4_code", 32'(key_code), 32'hF);
      chk("t4_scan_ena", 32'(scan_ena), 32'h0);
      chk("t4_col_n", 32'(col_n), 32'h7);
    end
    scan_tick = 1'b0;
    step();
    key_ready = 1'b1;
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    chk("t4_acc_valid", 32'(key_valid), 32'h0);
    chk("t4_acc_scan_ena", 32'(scan_ena), 32'h1);
    chk("t4_acc_count", 32'(n_acc), 32'(n_pushed));
    set_key(3, 3, 1'b0);
    ticks(3);
    chk("t4_rel_held3", 32'(key_held), 32'h1);
    tick();
    chk("t4_rel_held4", 32'(key_held), 32'h0);
    chk("t4_rel_col", 32'(col_n), 32'hE);

    // 5: rows 1 and 3 on col 0 -> code 4 only; release chatter
    push_exp(4);
    pressed[3][0] = 1'b1;
    set_key(1, 0, 1'b1);
    ticks(5);
    chk("t5_held", 32'(key_held), 32'h1);
    set_key(1, 0, 1'b0);
    ticks(2);
    set_key(1, 0, 1'b1);
    tick();
    set_key(1, 0, 1'b0);
    ticks(3);
    chk("t5_chatter_held", 32'(key_held), 32'h1);
    tick();
    chk("t5_rel_held", 32'(key_held), 32'h0);
    chk("t5_rel_col", 32'(col_n), 32'hD);
    set_key(3, 0, 1'b0);

    // 6: async reset while holding an unaccepted key
    key_ready = 1'b0;
    set_key(0, 1, 1'b1);
    ticks(5);
    chk("t6_hold_valid", 32'(key_valid), 32'h1);
    chk("t6_hold_code", 32'(key_code), 32'h1);
    chk("t6_hold_scan_ena", 32'(scan_ena), 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_col_n", 32'(col_n), 32'hE);
    chk("t6_rst_scan_ena", 32'(scan_ena), 32'h1);
    chk("t6_rst_valid", 32'(key_valid), 32'h0);
    chk("t6_rst_code", 32'(key_code), 32'h0);
    chk("t6_rst_held", 32'(key_held), 32'h0);
    pressed = '0;
    repeat (3) step();
    rst_n = 1'b1;
    key_ready = 1'b1;
    step();
    chk("t6_post_col", 32'(col_n), 32'hE);
    tick();
    chk("t6_restart_col", 32'(col_n), 32'hD);
    chk("t6_restart_valid", 32'(key_valid), 32'h0);

    repeat (4) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("final_accepts", 32'(n_acc), 32'(n_pushed));
    summary();
    $finish;
  end

endmodule
